fu2_arb: RTL
============

# fu2_arb

Two-port issue arbiter and result router for the `fu2` functional unit. It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It drives `fu2` from registered operand/control outputs and tracks in-flight operations in a tag pipeline, steering each `fu2` result and its flags back to the requester that issued it. A flush sequence drains the unit before mode changes.

## Interface
Parameters:
- DSIZE, 64, operand/result width
- OPSIZE, 5, width of OP1/OP2
- ASIZE, 6, width of SHF_AMT
- LAT, 1, `fu2` latency: cycles from operand launch edge to result sample edge (legal 1..8)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- REQ0_VALID / REQ1_VALID  in  1  request valid
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle (combinational)
- REQ0_OPND / REQ1_OPND  in  4*DSIZE  {A,B,C,D}, A in MSBs
- REQ0_CTRL / REQ1_CTRL  in  2*OPSIZE+ASIZE+3  {SEL,SHF_MODE[1:0],SHF_AMT,OP1,OP2}, SEL in MSB
- FU_A, FU_B, FU_C, FU_D  out  DSIZE  registered operands to `fu2`
- FU_OP1, FU_OP2  out  OPSIZE  registered opcodes
- FU_SHF_AMT  out  ASIZE; FU_SHF_MODE  out  2; FU_SEL  out  1
- FU_OUT  in  DSIZE; FU_Z, FU_N, FU_R, FU_O  in  1  result and flags from `fu2`
- RSP0_VALID / RSP1_VALID  out  1  one-cycle result strobe per requester
- RSP_DATA  out  DSIZE+4  {OUT,Z,N,R,O}, shared by both requesters
- FLUSH  in  1  drain request (level sampled in RUN)
- FLUSH_DONE  out  1  one-cycle pulse when drain completes
- ISSUE_CNT, CONFLICT_CNT  out  32  statistics (see Configuration)

## Operation
- FSM states: RUN, DRAIN, DONE. Reset state is RUN.
- RUN with FLUSH=1 goes to DRAIN. No grant is given in that cycle.
- DRAIN goes to DONE in the first cycle the tag pipeline holds no valid entry.
- DONE lasts one cycle, FLUSH_DONE=1, then returns to RUN.
- Grants are issued only in RUN with FLUSH=0.
  - If exactly one VALID is high, that requester is granted.
  - If both are high, the requester selected by the round-robin pointer `ptr` is granted.
  - READYn = grantn. A transfer occurs when VALID&READY.
- After each transfer by requester n, `ptr` becomes the other requester. With no transfer, `ptr` is unchanged. Reset value of `ptr` is 0.
- On a transfer, the granted OPND/CTRL fields load FU_* at that edge. With no transfer, FU_* hold their previous values.
- Tag pipeline has LAT stages of {v, id}. The transfer inserts {1, n} at stage 0. An idle cycle inserts {0, x}. The pipeline shifts every cycle.
- When the last stage is valid, {FU_OUT,FU_Z,FU_N,FU_R,FU_O} is registered into RSP_DATA and RSPid_VALID is set for one cycle. RSP_DATA holds between strobes.
- There is no response backpressure. Requesters must always accept RSPn_VALID.
- Back-to-back issue, one operation per cycle, is supported in either order.

## Timing
- All outputs reset to 0 with RST=1 at an edge: FU_*, RSP_DATA, RSP*_VALID, FLUSH_DONE, and tag valids. The FSM returns to RUN and `ptr`=0.
- Reset mid-operation discards in-flight results. No RSP_VALID is asserted for them after reset.
- Latency for a transfer at edge t:
  - FU_* update at edge t.
  - `fu2` result is sampled at edge t+LAT.
  - RSPn_VALID is high from edge t+LAT to edge t+LAT+1, i.e. request-to-response is LAT cycles.
- READY depends combinationally on VALID, FSM state, FLUSH and `ptr`. It never depends on RSP outputs.
- FLUSH arriving in the same cycle as VALID: no grant. The request waits until after DONE.
- FLUSH with an empty pipeline: DRAIN then DONE. FLUSH_DONE follows 2 cycles after the FLUSH edge.

## Configuration
- `FU2_ARB_STAT_EN` defined: two statistics counters are implemented. Both are cleared by RST and saturate at 32'hFFFF_FFFF.
  - ISSUE_CNT increments on every transfer.
  - CONFLICT_CNT increments on every RUN cycle with FLUSH=0 and both VALIDs high.
- Not defined: the ports remain and are tied to 0. No counter logic is synthesized.

## Test plan
- Single issue, LAT=1: REQ0 with A=5,B=3 and an add opcode at edge t -> FU_A=5 after edge t. RSP0_VALID=1 for exactly one cycle after edge t+1 with RSP_DATA={8,Z0,N0,R0,O0}. RSP1_VALID stays 0.
- Contention: both VALID held high for 6 cycles from reset -> grants alternate 0,1,0,1,0,1. Responses arrive in the same order with the correct RSPn_VALID per id. CONFLICT_CNT=6 and ISSUE_CNT=6 with `FU2_ARB_STAT_EN`.
- LAT=3, back-to-back: REQ1 issues 4 consecutive ops -> 4 consecutive RSP1_VALID pulses starting 3 cycles after the first transfer. Data order matches issue order.
- Flush: FLUSH pulsed with 2 ops in flight, LAT=3 -> READY low throughout. Both responses are delivered. FLUSH_DONE pulses once in the cycle after the pipeline empties. Grants resume the next cycle.
- Reset mid-flight: RST asserted 1 cycle after issue, LAT=3 -> no RSP*_VALID afterwards. FU_*, RSP_DATA and counters read 0. The next REQ0 is granted first (`ptr`=0).

Source files
------------

// File: rtl/fu2_arb_if.sv
// fu2_arb_if: handshake and data bus between the two requesters, the fu2_arb
// arbiter and the fu2 functional unit.
//
// Signal groups:
//   req0_* / req1_*  request valid/ready, operands {A,B,C,D} and control
//                    {SEL,SHF_MODE,SHF_AMT,OP1,OP2}
//   fu_*             registered operands/controls to fu2 and its result/flags
//   rsp*             per-requester result strobes and shared result data
//
// Modports:
//   slave   the arbiter side (fu2_arb)
//   master  the requester / functional-unit side
interface fu2_arb_if #(
    parameter int unsigned DSIZE  = 64,
    parameter int unsigned OPSIZE = 5,
    parameter int unsigned ASIZE  = 6
);
    localparam int unsigned CW = 2 * OPSIZE + ASIZE + 3;

    logic                 req0_valid;
    logic                 req0_ready;
    logic [4*DSIZE-1:0]   req0_opnd;
    logic [CW-1:0]        req0_ctrl;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [4*DSIZE-1:0]   req1_opnd;
    logic [CW-1:0]        req1_ctrl;

    logic [DSIZE-1:0]     fu_a;
    logic [DSIZE-1:0]     fu_b;
    logic [DSIZE-1:0]     fu_c;
    logic [DSIZE-1:0]     fu_d;
    logic [OPSIZE-1:0]    fu_op1;
    logic [OPSIZE-1:0]    fu_op2;
    logic [ASIZE-1:0]     fu_shf_amt;
    logic [1:0]           fu_shf_mode;
    logic                 fu_sel;
    logic [DSIZE-1:0]     fu_out;
    logic                 fu_z;
    logic                 fu_n;
    logic                 fu_r;
    logic                 fu_o;

    logic                 rsp0_valid;
    logic                 rsp1_valid;
    logic [DSIZE+3:0]     rsp_data;

    modport slave (
        input  req0_valid, req0_opnd, req0_ctrl,
        input  req1_valid, req1_opnd, req1_ctrl,
        output req0_ready, req1_ready,
        output fu_a, fu_b, fu_c, fu_d, fu_op1, fu_op2, fu_shf_amt, fu_shf_mode, fu_sel,
        input  fu_out, fu_z, fu_n, fu_r, fu_o,
        output rsp0_valid, rsp1_valid, rsp_data
    );

    modport master (
        output req0_valid, req0_opnd, req0_ctrl,
        output req1_valid, req1_opnd, req1_ctrl,
        input  req0_ready, req1_ready,
        input  fu_a, fu_b, fu_c, fu_d, fu_op1, fu_op2, fu_shf_amt, fu_shf_mode, fu_sel,
        output fu_out, fu_z, fu_n, fu_r, fu_o,
        input  rsp0_valid, rsp1_valid, rsp_data
    );
endinterface

// File: rtl/fu2_arb.sv
// fu2_arb: two-port round-robin issue arbiter and result router for fu2.
//
// Requests from two requesters are granted round-robin, their operands and
// controls are registered onto the fu2 inputs, and a LAT-deep tag pipeline
// steers each fu2 result back to the requester that issued it. A flush drains
// the tag pipeline (RUN -> DRAIN -> DONE -> RUN) with no grants meanwhile.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   bus             fu2_arb_if.slave: request handshakes, fu2 drive/result,
//                   response strobes and data
//   flush_i         drain request, level sampled in RUN
//   flush_done_o    one-cycle pulse when the drain completes
//   issue_cnt_o     saturating transfer count
//   conflict_cnt_o  saturating count of RUN cycles with both requests valid
//
// Build option: define FU2_ARB_STAT_EN to implement the two statistics
// counters; otherwise both counter outputs are tied to zero.
module fu2_arb #(
    parameter int unsigned DSIZE  = 64,
    parameter int unsigned OPSIZE = 5,
    parameter int unsigned ASIZE  = 6,
    parameter int unsigned LAT    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    fu2_arb_if.slave    bus,
    input  logic        flush_i,
    output logic        flush_done_o,
    output logic [31:0] issue_cnt_o,
    output logic [31:0] conflict_cnt_o
);
    localparam int unsigned CW = 2 * OPSIZE + ASIZE + 3;

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               gnt0, gnt1, xfer;
    logic [LAT-1:0]     tag_v_q, tag_v_d;
    logic [LAT-1:0]     tag_id_q, tag_id_d;
    logic [4*DSIZE-1:0] opnd_sel;
    logic [CW-1:0]      ctrl_sel;

    logic [DSIZE-1:0]   fu_a_q, fu_b_q, fu_c_q, fu_d_q;
    logic [OPSIZE-1:0]  fu_op1_q, fu_op2_q;
    logic [ASIZE-1:0]   fu_shf_amt_q;
    logic [1:0]         fu_shf_mode_q;
    logic               fu_sel_q;
    logic               rsp0_valid_q, rsp1_valid_q;
    logic [DSIZE+3:0]   rsp_data_q;

    // Grants only in RUN with no flush; on contention ptr picks the winner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StRun && !flush_i) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = !ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign xfer           = gnt0 | gnt1;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    assign opnd_sel = gnt1 ? bus.req1_opnd : bus.req0_opnd;
    assign ctrl_sel = gnt1 ? bus.req1_ctrl : bus.req0_ctrl;

    // Stage 0 takes the new issue, older stages shift toward LAT-1.
    always_comb begin
        tag_v_d     = tag_v_q << 1;
        tag_id_d    = tag_id_q << 1;
        tag_v_d[0]  = xfer;
        tag_id_d[0] = gnt1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (flush_i) state_d = StDrain;
            StDrain: if (tag_v_q == '0) state_d = StDone;
            StDone:  state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    assign flush_done_o = (state_q == StDone);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StRun;
            ptr_q         <= 1'b0;
            tag_v_q       <= '0;
            tag_id_q      <= '0;
            fu_a_q        <= '0;
            fu_b_q        <= '0;
            fu_c_q        <= '0;
            fu_d_q        <= '0;
            fu_op1_q      <= '0;
            fu_op2_q      <= '0;
            fu_shf_amt_q  <= '0;
            fu_shf_mode_q <= '0;
            fu_sel_q      <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            if (xfer) begin
                fu_a_q        <= opnd_sel[4*DSIZE-1 -: DSIZE];
                fu_b_q        <= opnd_sel[3*DSIZE-1 -: DSIZE];
                fu_c_q        <= opnd_sel[2*DSIZE-1 -: DSIZE];
                fu_d_q        <= opnd_sel[DSIZE-1:0];
                fu_sel_q      <= ctrl_sel[CW-1];
                fu_shf_mode_q <= ctrl_sel[CW-2 -: 2];
                fu_shf_amt_q  <= ctrl_sel[2*OPSIZE+ASIZE-1 -: ASIZE];
                fu_op1_q      <= ctrl_sel[2*OPSIZE-1 -: OPSIZE];
                fu_op2_q      <= ctrl_sel[OPSIZE-1:0];
            end
            // The last tag stage marks the cycle fu2's result is valid.
            rsp0_valid_q <= tag_v_q[LAT-1] & ~tag_id_q[LAT-1];
            rsp1_valid_q <= tag_v_q[LAT-1] & tag_id_q[LAT-1];
            if (tag_v_q[LAT-1]) begin
                rsp_data_q <= {bus.fu_out, bus.fu_z, bus.fu_n, bus.fu_r, bus.fu_o};
            end
        end
    end

    assign bus.fu_a        = fu_a_q;
    assign bus.fu_b        = fu_b_q;
    assign bus.fu_c        = fu_c_q;
    assign bus.fu_d        = fu_d_q;
    assign bus.fu_op1      = fu_op1_q;
    assign bus.fu_op2      = fu_op2_q;
    assign bus.fu_shf_amt  = fu_shf_amt_q;
    assign bus.fu_shf_mode = fu_shf_mode_q;
    assign bus.fu_sel      = fu_sel_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp_data    = rsp_data_q;

`ifdef FU2_ARB_STAT_EN
    logic [31:0] issue_cnt_q, conflict_cnt_q;
    logic        conflict;

    assign conflict = (state_q == StRun) && !flush_i && bus.req0_valid && bus.req1_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (xfer && issue_cnt_q != 32'hFFFF_FFFF) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            if (conflict && conflict_cnt_q != 32'hFFFF_FFFF) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign issue_cnt_o    = issue_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign issue_cnt_o    = 32'd0;
    assign conflict_cnt_o = 32'd0;
`endif
endmodule
